// File: rtl/seg8_4_mux.sv
// seg8_4_mux: scanning driver for a 4-digit, 8-segment display.
// Shows a 16-bit value as four hex digits, each with its own decimal point.
module seg8_4_mux #(
    parameter int SCAN_DIV       = 16384,
    parameter bit SEL_ACTIVE_LOW = 1'b1,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] number,
    input  logic [3:0]  dot,
    output logic [3:0]  sel,
    output logic [7:0]  seg
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PLAST = PW'(SCAN_DIV - 1);

    // XOR masks: all-inactive values, also used to flip active-high to pin polarity
    localparam logic [3:0] SEL_OFF = SEL_ACTIVE_LOW ? 4'hF : 4'h0;
    localparam logic [7:0] SEG_OFF = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;

    generate
        if (SCAN_DIV < 1) begin : g_bad_scan_div
            $fatal(1, "seg8_4_mux: SCAN_DIV must be >= 1");
        end
    endgenerate

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0:    s = 7'h3F;
            4'h1:    s = 7'h06;
            4'h2:    s = 7'h5B;
            4'h3:    s = 7'h4F;
            4'h4:    s = 7'h66;
            4'h5:    s = 7'h6D;
            4'h6:    s = 7'h7D;
            4'h7:    s = 7'h07;
            4'h8:    s = 7'h7F;
            4'h9:    s = 7'h6F;
            4'hA:    s = 7'h77;
            4'hB:    s = 7'h7C;
            4'hC:    s = 7'h39;
            4'hD:    s = 7'h5E;
            4'hE:    s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    logic [PW-1:0] pcnt_q, pcnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [3:0]    sel_q, sel_d;
    logic [7:0]    seg_q, seg_d;
    logic [3:0]    nib;

    always_comb begin
        pcnt_d = pcnt_q + 1'b1;
        idx_d  = idx_q;
        if (pcnt_q == PLAST) begin
            pcnt_d = '0;
            idx_d  = idx_q + 2'd1;
        end
        nib   = number[{idx_q, 2'b00} +: 4];
        sel_d = (4'b0001 << idx_q) ^ SEL_OFF;
        seg_d = {dot[idx_q], hex7(nib)} ^ SEG_OFF;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt_q <= '0;
            idx_q  <= 2'd0;
            sel_q  <= SEL_OFF;
            seg_q  <= SEG_OFF;
        end else begin
            pcnt_q <= pcnt_d;
            idx_q  <= idx_d;
            sel_q  <= sel_d;
            seg_q  <= seg_d;
        end
    end

    assign sel = sel_q;
    assign seg = seg_q;

endmodule

// File: tb/tb_seg8_4_mux.sv
// tb_seg8_4_mux: scoreboard bench for the display scanner.
// Main instance uses SCAN_DIV=4 active-low; second uses SCAN_DIV=1 active-high.
module tb_seg8_4_mux;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rst2 = 1'b1;
    logic [15:0] number = 16'h0000;
    logic [3:0]  dot = 4'h0;
    logic [3:0]  sel, sel2;
    logic [7:0]  seg, seg2;

    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        logic [3:0] sel;
        logic [7:0] seg;
    } exp_t;

    exp_t sbq[$];
    exp_t sbq2[$];

    logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    logic [3:0] sel_tab [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
    logic [7:0] t2_seg [4]  = '{8'h99, 8'hB0, 8'hA4, 8'hF9};
    logic [7:0] t3_seg [4]  = '{8'h46, 8'hA1, 8'h06, 8'h8E};

    int m_idx = 0;
    int m_pcnt = 0;

    always #5 clk = ~clk;

    seg8_4_mux #(
        .SCAN_DIV(4), .SEL_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1)
    ) u_dut (
        .clk(clk), .rst(rst), .number(number), .dot(dot), .sel(sel), .seg(seg)
    );

    seg8_4_mux #(
        .SCAN_DIV(1), .SEL_ACTIVE_LOW(1'b0), .SEG_ACTIVE_LOW(1'b0)
    ) u_dut2 (
        .clk(clk), .rst(rst2), .number(16'h0000), .dot(4'h0), .sel(sel2), .seg(seg2)
    );

    task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", tag, act, exp);
        end
    endtask

    // One clock on the main DUT: predict, push, clock, pop and compare.
    task automatic tick(input string tag);
        exp_t e;
        int   nib;
        if (rst) begin
            e.sel = 4'hF;
            e.seg = 8'hFF;
            m_idx = 0;
            m_pcnt = 0;
        end else begin
            nib = number[m_idx*4 +: 4];
            e.sel = ~(4'b0001 << m_idx);
            e.seg = ~{dot[m_idx], hex_tab[nib]};
            if (m_pcnt == 3) begin
                m_pcnt = 0;
                m_idx = (m_idx + 1) % 4;
            end else begin
                m_pcnt++;
            end
        end
        sbq.push_back(e);
        @(posedge clk);
        #1;
        if (sbq.size() == 0) begin
            chk({tag, "_sbq_empty"}, 8'h00, 8'h01);
        end else begin
            e = sbq.pop_front();
            chk({tag, "_sel"}, {4'h0, sel}, {4'h0, e.sel});
            chk({tag, "_seg"}, seg, e.seg);
        end
    endtask

    initial begin
        exp_t e2;

        // 1: reset state, then first digit after release
        number = 16'h1234;
        dot = 4'h0;
        for (int i = 0; i < 3; i++) tick("t1_rst");
        chk("t1_rst_seg_ff", seg, 8'hFF);
        rst = 1'b0;

        // 2: free run, four-clock dwell per digit, wrap back to digit 0
        for (int k = 0; k < 17; k++) begin
            tick("t2_run");
            chk("t2_sel_const", {4'h0, sel}, {4'h0, sel_tab[(k / 4) % 4]});
            chk("t2_seg_const", seg, t2_seg[(k / 4) % 4]);
        end

        // 3: hex letters with alternating decimal points
        rst = 1'b1;
        tick("t3_rst");
        rst = 1'b0;
        number = 16'hFEDC;
        dot = 4'b0101;
        for (int k = 0; k < 16; k++) begin
            tick("t3_run");
            chk("t3_seg_const", seg, t3_seg[k / 4]);
        end

        // 4: reset while digit 2 is showing restarts with a full dwell
        rst = 1'b1;
        tick("t4_rst");
        rst = 1'b0;
        for (int k = 0; k < 9; k++) tick("t4_pre");
        chk("t4_on_digit2", {4'h0, sel}, 8'h0B);
        rst = 1'b1;
        tick("t4_mid_rst");
        chk("t4_mid_rst_sel", {4'h0, sel}, 8'h0F);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick("t4_post");
            chk("t4_dwell_sel", {4'h0, sel}, {4'h0, sel_tab[k / 4]});
        end

        // 5: number change mid-dwell shows on the next clock
        number = 16'h1234;
        tick("t5_change");
        chk("t5_sel_same", {4'h0, sel}, 8'h0D);
        chk("t5_seg_new", seg, 8'hB0);

        // 6: SCAN_DIV=1, active-high pins, digit advances every clock
        e2.sel = 4'h0;
        e2.seg = 8'h00;
        sbq2.push_back(e2);
        @(posedge clk);
        #1;
        e2 = sbq2.pop_front();
        chk("t6_rst_sel", {4'h0, sel2}, {4'h0, e2.sel});
        chk("t6_rst_seg", seg2, e2.seg);
        rst2 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            e2.sel = 4'b0001 << (k % 4);
            e2.seg = {1'b0, hex_tab[0]};
            sbq2.push_back(e2);
            @(posedge clk);
            #1;
            e2 = sbq2.pop_front();
            chk("t6_sel", {4'h0, sel2}, {4'h0, e2.sel});
            chk("t6_seg", seg2, e2.seg);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
